// File: rtl/conv_frame_sequencer_if.sv
// Control/handshake bundle between the frame sequencer and its environment:
// upstream pixel stream, pixel-controller feed, output-buffer status and
// the host-facing start/abort/interrupt signals.
interface conv_frame_sequencer_if #(
  parameter int DIM_W = 12
);
  logic             i_start;
  logic             i_abort;
  logic [DIM_W-1:0] i_cfg_width;
  logic [DIM_W-1:0] i_cfg_height;
  logic             i_s_valid;
  logic [7:0]       i_s_data;
  logic             o_s_ready;
  logic             o_pix_valid;
  logic [7:0]       o_pix_data;
  logic             i_line_intr;
  logic             i_prog_full;
  logic             i_out_fire;
  logic             i_intr_clr;
  logic             o_busy;
  logic             o_done;
  logic             o_intr;
  logic             o_err;

  // Sequencer side
  modport slave (
    input  i_start, i_abort, i_cfg_width, i_cfg_height,
    input  i_s_valid, i_s_data, i_line_intr, i_prog_full,
    input  i_out_fire, i_intr_clr,
    output o_s_ready, o_pix_valid, o_pix_data,
    output o_busy, o_done, o_intr, o_err
  );

  // Environment side
  modport master (
    output i_start, i_abort, i_cfg_width, i_cfg_height,
    output i_s_valid, i_s_data, i_line_intr, i_prog_full,
    output i_out_fire, i_intr_clr,
    input  o_s_ready, o_pix_valid, o_pix_data,
    input  o_busy, o_done, o_intr, o_err
  );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the 3x3 convolution pipeline.
// Gates upstream pixels with a line-buffer credit count, holds off on
// output-buffer backpressure, counts output beats to find end-of-frame and
// raises sticky frame-done / error flags.
module conv_frame_sequencer #(
  parameter int LINE_BUFS = 4,
  parameter int DIM_W     = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  conv_frame_sequencer_if.slave bus
);

  localparam int CNT_W = 24;
  localparam int CR_W  = $clog2(LINE_BUFS + 1);
  localparam logic [CR_W-1:0] CREDIT_MAX = CR_W'(LINE_BUFS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [DIM_W-1:0] width_q, width_d;
  logic [DIM_W-1:0] height_q, height_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] line_q, line_d;
  logic [CR_W-1:0]  credit_q, credit_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] expect_q, expect_d;
  logic             intr_q, intr_d;
  logic             err_q, err_d;

  logic geom_ok;
  logic start_ok;
  logic start_bad;
  logic counting;
  logic s_ready;
  logic accept;
  logic line_done;
  logic credit_ovf;

  assign geom_ok   = (bus.i_cfg_width  >= DIM_W'(3)) &&
                     (bus.i_cfg_height >= DIM_W'(3));
  assign start_ok  = !bus.i_abort && (state_q == S_IDLE) && bus.i_start && geom_ok;
  assign start_bad = !bus.i_abort && (state_q == S_IDLE) && bus.i_start && !geom_ok;
  assign counting  = (state_q == S_RUN) || (state_q == S_DRAIN);

  assign s_ready   = (state_q == S_RUN) && (credit_q != '0) &&
                     !bus.i_prog_full && (line_q < height_q);
  assign accept    = bus.i_s_valid && s_ready;
  assign line_done = accept && (col_q == width_q - DIM_W'(1));

  assign bus.o_s_ready   = s_ready;
  assign bus.o_pix_valid = accept;
  assign bus.o_pix_data  = bus.i_s_data;
  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_done      = (state_q == S_DONE);
  assign bus.o_intr      = intr_q;
  assign bus.o_err       = err_q;

  // Geometry latch, pixel position, credit and output-beat counters
  always_comb begin
    width_d    = width_q;
    height_d   = height_q;
    col_d      = col_q;
    line_d     = line_q;
    credit_d   = credit_q;
    out_cnt_d  = out_cnt_q;
    expect_d   = expect_q;
    credit_ovf = 1'b0;

    if (start_ok) begin
      width_d   = bus.i_cfg_width;
      height_d  = bus.i_cfg_height;
      col_d     = '0;
      line_d    = '0;
      credit_d  = CREDIT_MAX;
      out_cnt_d = '0;
      expect_d  = CNT_W'(bus.i_cfg_width) * (CNT_W'(bus.i_cfg_height) - CNT_W'(2));
    end else if (!bus.i_abort && counting) begin
      if (accept) begin
        if (line_done) begin
          col_d  = '0;
          line_d = line_q + DIM_W'(1);
        end else begin
          col_d  = col_q + DIM_W'(1);
        end
      end

      // A line consumed and a line freed in the same cycle cancel out
      if (line_done && !bus.i_line_intr) begin
        credit_d = credit_q - CR_W'(1);
      end else if (!line_done && bus.i_line_intr) begin
        if (credit_q == CREDIT_MAX) begin
          credit_ovf = 1'b1;
        end else begin
          credit_d = credit_q + CR_W'(1);
        end
      end

      if (bus.i_out_fire) begin
        out_cnt_d = out_cnt_q + CNT_W'(1);
      end
    end
  end

  // Frame FSM next-state; end-of-frame uses the post-increment beat count
  // so DONE follows the final beat by exactly one cycle
  always_comb begin
    state_d = state_q;
    if (bus.i_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (out_cnt_d == expect_q) begin
            state_d = S_DONE;
          end else if (line_q == height_q) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_cnt_d == expect_q) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Sticky interrupt and error flags; a set in the same cycle beats a clear
  always_comb begin
    intr_d = intr_q;
    err_d  = err_q;
    if (bus.i_intr_clr) begin
      intr_d = 1'b0;
      err_d  = 1'b0;
    end
    if (start_bad || credit_ovf) begin
      err_d = 1'b1;
    end
    if (state_d == S_DONE) begin
      intr_d = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter, geometry and flag registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      width_q   <= '0;
      height_q  <= '0;
      col_q     <= '0;
      line_q    <= '0;
      credit_q  <= '0;
      out_cnt_q <= '0;
      expect_q  <= '0;
      intr_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      width_q   <= width_d;
      height_q  <= height_d;
      col_q     <= col_d;
      line_q    <= line_d;
      credit_q  <= credit_d;
      out_cnt_q <= out_cnt_d;
      expect_q  <= expect_d;
      intr_q    <= intr_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer: a frame-level model
// (pixels sent, credits, beats seen) predicts every output each cycle,
// with directed scenarios and randomized frames as stimulus.
module tb_conv_frame_sequencer;
  localparam int LB = 4;
  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_frame_sequencer_if #(.DIM_W(DW)) bus ();

  conv_frame_sequencer #(
    .LINE_BUFS(LB),
    .DIM_W    (DW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Frame model: phase 0 idle, 1 active frame, 2 end-of-frame cycle
  int m_ph = 0;
  int m_W = 0;
  int m_H = 0;
  int m_sent = 0;
  int m_credit = 0;
  int m_outs = 0;
  bit m_intr = 0;
  bit m_err = 0;

  int dut_acc = 0;
  int dut_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    bit rdy, pv, ld, set_i, set_e;
    if (rst) begin
      m_ph = 0; m_W = 0; m_H = 0; m_sent = 0; m_credit = 0; m_outs = 0;
      m_intr = 0; m_err = 0;
    end else begin
      rdy = (m_ph == 1) && (m_sent < m_W * m_H) && (m_credit > 0) && !bus.i_prog_full;
      pv  = rdy && bus.i_s_valid;
      chk("s_ready",   32'(bus.o_s_ready),   32'(rdy));
      chk("pix_valid", 32'(bus.o_pix_valid), 32'(pv));
      if (pv) chk("pix_data", 32'(bus.o_pix_data), 32'(bus.i_s_data));
      chk("busy", 32'(bus.o_busy), 32'(m_ph != 0));
      chk("done", 32'(bus.o_done), 32'(m_ph == 2));
      chk("intr", 32'(bus.o_intr), 32'(m_intr));
      chk("err",  32'(bus.o_err),  32'(m_err));
      dut_acc  += bus.o_pix_valid ? 1 : 0;
      dut_done += bus.o_done ? 1 : 0;

      set_i = 0;
      set_e = 0;
      if (bus.i_abort) begin
        m_ph = 0;
      end else if (m_ph == 0) begin
        if (bus.i_start) begin
          if (bus.i_cfg_width >= 3 && bus.i_cfg_height >= 3) begin
            m_W = int'(bus.i_cfg_width);
            m_H = int'(bus.i_cfg_height);
            m_sent = 0; m_credit = LB; m_outs = 0; m_ph = 1;
          end else begin
            set_e = 1;
          end
        end
      end else if (m_ph == 1) begin
        ld = pv && (((m_sent + 1) % m_W) == 0);
        m_sent += pv ? 1 : 0;
        if (ld && !bus.i_line_intr) m_credit--;
        else if (!ld && bus.i_line_intr) begin
          if (m_credit == LB) set_e = 1;
          else m_credit++;
        end
        if (bus.i_out_fire) m_outs++;
        if (m_outs == m_W * (m_H - 2)) begin
          m_ph = 2;
          set_i = 1;
        end
      end else begin
        m_ph = 0;
      end
      if (bus.i_intr_clr) begin
        m_intr = 0;
        m_err = 0;
      end
      if (set_i) m_intr = 1;
      if (set_e) m_err = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.i_s_data = 8'($urandom);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_inputs();
    bus.i_start = 0; bus.i_abort = 0; bus.i_s_valid = 0; bus.i_line_intr = 0;
    bus.i_prog_full = 0; bus.i_out_fire = 0; bus.i_intr_clr = 0;
  endtask

  task automatic start_frame(input int w, input int h);
    bus.i_cfg_width  = DW'(w);
    bus.i_cfg_height = DW'(h);
    bus.i_start = 1;
    tick();
    bus.i_start = 0;
  endtask

  task automatic pulse_intr();
    bus.i_line_intr = 1; tick(); bus.i_line_intr = 0;
  endtask

  task automatic pulse_clr();
    bus.i_intr_clr = 1; tick(); bus.i_intr_clr = 0;
  endtask

  task automatic pulse_abort();
    bus.i_abort = 1; tick(); bus.i_abort = 0;
  endtask

  task automatic fires(input int n);
    bus.i_out_fire = 1; ticks(n); bus.i_out_fire = 0;
  endtask

  task automatic run_random_frame(input int w, input int h);
    int budget, rows;
    start_frame(w, h);
    budget = 4000;
    while (m_ph != 0 && budget > 0) begin
      bus.i_s_valid   = ($urandom_range(0, 3) != 0);
      bus.i_prog_full = ($urandom_range(0, 7) == 0);
      bus.i_line_intr = (m_ph == 1) &&
                        ((m_credit < LB && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0);
      rows = m_sent / w;
      bus.i_out_fire  = (rows > 2 && m_outs < (rows - 2) * w) ? ($urandom_range(0, 1) == 1) : 1'b0;
      bus.i_intr_clr  = ($urandom_range(0, 49) == 0);
      bus.i_start     = (m_ph == 1) && ($urandom_range(0, 29) == 0);
      tick();
      budget--;
    end
    idle_inputs();
    chk("frame_completes_in_budget", 32'(budget > 0), 32'd1);
    for (int i = 0; i < 6; i++) begin
      bus.i_out_fire = ($urandom_range(0, 1) == 1);
      tick();
    end
    bus.i_out_fire = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, d0, budget;
    idle_inputs();
    bus.i_s_data = 8'h00;
    bus.i_cfg_width = '0;
    bus.i_cfg_height = '0;
    #1 rst = 1;
    #2;
    chk("rst_busy",      32'(bus.o_busy), 32'd0);
    chk("rst_done",      32'(bus.o_done), 32'd0);
    chk("rst_intr",      32'(bus.o_intr), 32'd0);
    chk("rst_err",       32'(bus.o_err), 32'd0);
    chk("rst_s_ready",   32'(bus.o_s_ready), 32'd0);
    chk("rst_pix_valid", 32'(bus.o_pix_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    tick();

    // Basic frame: 4 credits give 32 pixels, two returned lines give 16 more
    bus.i_s_valid = 1;
    base = dut_acc;
    start_frame(8, 6);
    ticks(50);
    chk("t1_first_burst", 32'(dut_acc - base), 32'd32);
    chk("t1_stalled_ready", 32'(bus.o_s_ready), 32'd0);
    chk("t1_model_credit", 32'(m_credit), 32'd0);
    pulse_intr();
    tick();
    pulse_intr();
    ticks(30);
    chk("t1_total", 32'(dut_acc - base), 32'd48);
    bus.i_s_valid = 0;
    d0 = dut_done;
    fires(32);
    chk("t1_done_pulse", 32'(bus.o_done), 32'd1);
    chk("t1_intr_set", 32'(bus.o_intr), 32'd1);
    tick();
    chk("t1_done_once", 32'(dut_done - d0), 32'd1);
    chk("t1_back_idle", 32'(bus.o_busy), 32'd0);
    pulse_clr();
    chk("t1_intr_cleared", 32'(bus.o_intr), 32'd0);

    // Backpressure mid-line: no accepts while prog_full, same totals
    bus.i_s_valid = 1;
    base = dut_acc;
    start_frame(8, 6);
    ticks(3);
    d0 = dut_acc;
    bus.i_prog_full = 1;
    ticks(10);
    chk("t2_no_accept_when_full", 32'(dut_acc - d0), 32'd0);
    bus.i_prog_full = 0;
    ticks(40);
    chk("t2_first_burst", 32'(dut_acc - base), 32'd32);
    pulse_intr();
    tick();
    pulse_intr();
    ticks(30);
    chk("t2_total", 32'(dut_acc - base), 32'd48);
    bus.i_s_valid = 0;
    d0 = dut_done;
    fires(32);
    tick();
    chk("t2_done_once", 32'(dut_done - d0), 32'd1);
    pulse_clr();

    // Line completion and freed buffer in the same cycle at credit 1
    bus.i_s_valid = 1;
    start_frame(4, 8);
    budget = 100;
    while (!(m_sent == 15 && m_credit == 1) && budget > 0) begin
      tick();
      budget--;
    end
    chk("t3_reach_point", 32'(budget > 0), 32'd1);
    bus.i_line_intr = 1;
    tick();
    bus.i_line_intr = 0;
    chk("t3_ready_kept", 32'(bus.o_s_ready), 32'd1);
    chk("t3_model_credit", 32'(m_credit), 32'd1);
    chk("t3_err_clear", 32'(bus.o_err), 32'd0);
    pulse_abort();
    bus.i_s_valid = 0;
    chk("t3_abort_ready", 32'(bus.o_s_ready), 32'd0);

    // Credit overflow at full credit
    start_frame(8, 6);
    pulse_intr();
    chk("t4_ovf_err", 32'(bus.o_err), 32'd1);
    chk("t4_model_credit", 32'(m_credit), 32'd4);
    pulse_clr();
    chk("t4_err_cleared", 32'(bus.o_err), 32'd0);
    pulse_abort();

    // Bad geometry, then abort mid-run
    start_frame(2, 10);
    chk("t5_bad_err", 32'(bus.o_err), 32'd1);
    chk("t5_bad_busy", 32'(bus.o_busy), 32'd0);
    pulse_clr();
    bus.i_s_valid = 1;
    start_frame(16, 16);
    ticks(20);
    d0 = dut_done;
    pulse_abort();
    chk("t5_abort_ready", 32'(bus.o_s_ready), 32'd0);
    chk("t5_abort_busy", 32'(bus.o_busy), 32'd0);
    ticks(5);
    chk("t5_no_done", 32'(dut_done - d0), 32'd0);
    chk("t5_no_intr", 32'(bus.o_intr), 32'd0);

    // Asynchronous reset mid-frame, then a minimal frame
    start_frame(8, 6);
    ticks(10);
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("t6_rst_ready", 32'(bus.o_s_ready), 32'd0);
    chk("t6_rst_pix_valid", 32'(bus.o_pix_valid), 32'd0);
    chk("t6_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("t6_rst_done", 32'(bus.o_done), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    base = dut_acc;
    start_frame(4, 3);
    ticks(20);
    chk("t6_pixels", 32'(dut_acc - base), 32'd12);
    bus.i_s_valid = 0;
    d0 = dut_done;
    fires(4);
    chk("t6_done_pulse", 32'(bus.o_done), 32'd1);
    tick();
    chk("t6_done_once", 32'(dut_done - d0), 32'd1);
    pulse_clr();

    // Randomized frames with an occasional invalid start
    for (int f = 0; f < 8; f++) begin
      run_random_frame(int'($urandom_range(3, 10)), int'($urandom_range(3, 8)));
      if (f % 3 == 1) begin
        start_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 12)));
        ticks(2);
        pulse_clr();
      end
    end

    idle_inputs();
    ticks(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_frame_sequencer.md
# conv_frame_sequencer

Frame-level controller for the 3x3 convolution pipeline. It sits between the upstream pixel stream and the line-buffer pixel controller and gates input pixels using a line-buffer credit scheme. Credits are replenished by the pixel controller's line-consumed interrupt, and input is also held off by output-buffer backpressure. It counts convolved output beats to detect end-of-frame and raises a sticky frame-done interrupt. Frame geometry is loaded at start, so one bitstream handles any image size.

## Interface
Parameters:
- LINE_BUFS, 4, number of line buffers in the pixel controller; initial and maximum credit
- DIM_W, 12, width of the frame-geometry inputs

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  start pulse; honoured only in IDLE
- i_abort  in  1  abort; returns to IDLE next cycle from any state
- i_cfg_width  in  DIM_W  pixels per line W, sampled on accepted start
- i_cfg_height  in  DIM_W  lines per frame H, sampled on accepted start
- i_s_valid  in  1  upstream pixel valid
- i_s_data  in  8  upstream pixel
- o_s_ready  out  1  upstream ready
- o_pix_valid  out  1  pixel valid to pixel controller
- o_pix_data  out  8  pixel to pixel controller (i_s_data passthrough)
- i_line_intr  in  1  one-cycle pulse from pixel controller: one line buffer freed
- i_prog_full  in  1  output-buffer programmable-full
- i_out_fire  in  1  output beat transferred (m_valid & m_ready)
- i_intr_clr  in  1  clears o_intr and o_err
- o_busy  out  1  high outside IDLE
- o_done  out  1  one-cycle end-of-frame pulse
- o_intr  out  1  sticky frame-done interrupt
- o_err  out  1  sticky: bad geometry or credit overflow

## Operation
- States: IDLE, RUN, DRAIN, DONE (registered FSM).
- IDLE:
  - On i_start, check W>=3 and H>=3. If valid, latch W and H, clear counters, set credit=LINE_BUFS, and go to RUN.
  - If invalid, set o_err and stay in IDLE.
- Counters:
  - col_cnt (DIM_W): 0..W-1, increments on every accepted pixel; wraps to 0 at W-1 and increments line_cnt.
  - line_cnt (DIM_W): lines fully sent.
  - credit (3b): free line buffers.
  - out_cnt (24b): output beats seen.
- Acceptance: o_s_ready = (state==RUN) & credit!=0 & !i_prog_full & line_cnt<H. Accept = i_s_valid & o_s_ready. o_pix_valid = accept. o_pix_data = i_s_data.
- Credit updates:
  - A line completion (accept at col_cnt==W-1) decrements credit.
  - An i_line_intr pulse increments credit.
  - Both in the same cycle: credit unchanged.
  - i_line_intr while credit==LINE_BUFS with no same-cycle completion: credit stays at LINE_BUFS and o_err is set.
- RUN -> DRAIN when line_cnt reaches H.
- out_cnt increments on i_out_fire in RUN or DRAIN; i_out_fire in IDLE/DONE is ignored. Expected output count is W*(H-2) (datapath emits W beats per output row, H-2 rows). The product is computed once at start into a 24-bit register.
- DRAIN -> DONE when out_cnt == W*(H-2). The check is also active in RUN, so the end can never be missed.
- DONE: o_done=1 for this single cycle; o_intr set; next state IDLE.
- i_abort: from any state, next state IDLE, o_s_ready low next cycle, counters frozen, no o_done or o_intr. i_abort has priority over i_start and all transitions.
- i_intr_clr clears o_intr and o_err. If the set and clear conditions occur in the same cycle, set wins.

## Timing
- Reset values: state IDLE, all counters 0, o_busy 0, o_done 0, o_intr 0, o_err 0, o_s_ready 0, o_pix_valid 0.
- o_busy is registered and rises the cycle after an accepted i_start.
- o_s_ready and o_pix_valid are combinational from registered state plus i_prog_full and i_s_valid. Pass-through latency is 0 cycles.
- A credit returned by i_line_intr in cycle N allows acceptance in cycle N+1.
- o_done is asserted one cycle after the final counted i_out_fire. o_intr is high from the same cycle until cleared.
- i_prog_full stalls acceptance in the same cycle it is high, with no skid.

## Test plan
- W=8, H=6, i_s_valid constant, no i_line_intr -> exactly 32 pixels accepted, then o_s_ready=0 with credit=0. Pulse i_line_intr twice -> 16 more accepted, then DRAIN. 32 i_out_fire -> o_done one cycle later, o_intr=1.
- Same frame with i_prog_full held high for 10 cycles mid-line -> no accepts during those cycles, col_cnt resumes at the exact index, total accepted still 48.
- Line completion and i_line_intr in the same cycle at credit=1 -> credit stays 1, o_s_ready stays high.
- i_line_intr while credit=4 -> o_err=1, credit=4. i_intr_clr -> o_err=0.
- i_start with W=2, H=10 -> o_err=1, o_busy stays 0. i_abort mid-RUN of a W=16, H=16 frame -> IDLE next cycle, o_s_ready=0, no o_done.
- i_rst asserted mid-frame -> all outputs at reset values immediately (asynchronous). A new i_start completes a W=4, H=3 frame with 4 outputs.
